// File: rtl/ir_assembler.sv
// rtl/ir_assembler.sv - variable-length instruction register fed by a byte stream
module ir_assembler #(
   parameter int DATA_W   = 8,
   parameter int MAX_OPER = 2,
   localparam int CNT_W   = $clog2(MAX_OPER + 1)
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       flush,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   output logic [DATA_W-1:0]          opcode,
   output logic [MAX_OPER*DATA_W-1:0] operand,
   output logic [CNT_W-1:0]           oper_cnt,
   output logic                       illegal
);

   typedef enum logic [1:0] {
      FETCH_OP  = 2'd0,
      FETCH_ARG = 2'd1,
      HOLD      = 2'd2
   } state_t;

   localparam logic [CNT_W:0] MAX_C = (CNT_W + 1)'(MAX_OPER);

   state_t           state;
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] cnt_f;

   assign cnt_f       = in_data[DATA_W-1 -: CNT_W];
   // Gated by reset_n so every output reads 0 while reset is held.
   assign in_ready    = reset_n && (state == FETCH_OP || state == FETCH_ARG);
   assign instr_valid = (state == HOLD);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= FETCH_OP;
         opcode   <= '0;
         operand  <= '0;
         oper_cnt <= '0;
         illegal  <= 1'b0;
         idx      <= '0;
      end else if (flush) begin
         state    <= FETCH_OP;
         opcode   <= '0;
         operand  <= '0;
         oper_cnt <= '0;
         illegal  <= 1'b0;
         idx      <= '0;
      end else begin
         case (state)
            FETCH_OP: begin
               if (in_valid) begin
                  opcode  <= in_data;
                  operand <= '0;
                  illegal <= 1'b0;
                  idx     <= '0;
                  if ({1'b0, cnt_f} > MAX_C) begin
                     oper_cnt <= '0;
                     illegal  <= 1'b1;
                     state    <= HOLD;
                  end else if (cnt_f == '0) begin
                     oper_cnt <= '0;
                     state    <= HOLD;
                  end else begin
                     oper_cnt <= cnt_f;
                     state    <= FETCH_ARG;
                  end
               end
            end
            FETCH_ARG: begin
               if (in_valid) begin
                  for (int k = 0; k < MAX_OPER; k++) begin
                     if (idx == CNT_W'(k)) operand[k*DATA_W +: DATA_W] <= in_data;
                  end
                  // idx restarts on the last operand so it never passes MAX_OPER-1.
                  if (idx == oper_cnt - 1'b1) begin
                     idx   <= '0;
                     state <= HOLD;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (instr_ready) state <= FETCH_OP;
            end
            default: state <= FETCH_OP;
         endcase
      end
   end

endmodule

// File: tb/tb_ir_assembler.sv
// tb/tb_ir_assembler.sv - directed self-checking bench for ir_assembler
module tb_ir_assembler;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        flush = 1'b0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [7:0]  opcode;
   logic [15:0] operand;
   logic [1:0]  oper_cnt;
   logic        illegal;

   int n_checks = 0;
   int n_pass   = 0;

   ir_assembler #(.DATA_W(8), .MAX_OPER(2)) dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .flush(flush), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .opcode(opcode), .operand(operand),
      .oper_cnt(oper_cnt), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      check("push_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
      in_data  = 8'hEE;
   endtask

   task automatic consume();
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check("consume_valid_low", 32'(instr_valid), 32'd0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $finish;
   end

   initial begin
      // 1: reset mid FETCH_ARG
      tick();
      reset_n = 1'b1;
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_valid", 32'(instr_valid), 32'd0);
      push(8'h83);
      push(8'h12);
      reset_n = 1'b0;
      #1;
      check("arst_opcode", 32'(opcode), 32'h0);
      check("arst_operand", 32'(operand), 32'h0);
      check("arst_cnt", 32'(oper_cnt), 32'h0);
      check("arst_in_ready", 32'(in_ready), 32'd0);
      check("arst_valid", 32'(instr_valid), 32'd0);
      #2;
      reset_n = 1'b1;
      tick();
      check("rel_in_ready", 32'(in_ready), 32'd1);
      check("rel_valid", 32'(instr_valid), 32'd0);

      // 2: zero-operand opcode
      push(8'h05);
      check("t2_valid", 32'(instr_valid), 32'd1);
      check("t2_opcode", 32'(opcode), 32'h05);
      check("t2_cnt", 32'(oper_cnt), 32'd0);
      check("t2_operand", 32'(operand), 32'h0000);
      check("t2_illegal", 32'(illegal), 32'd0);
      consume();

      // 3: two operands with gaps, held under backpressure
      push(8'h83);
      in_data = 8'hFF;
      tick();
      check("t3_gap_ready", 32'(in_ready), 32'd1);
      check("t3_gap_valid", 32'(instr_valid), 32'd0);
      push(8'h12);
      tick();
      tick();
      push(8'h34);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h55;
         check("t3_opcode", 32'(opcode), 32'h83);
         check("t3_operand", 32'(operand), 32'h3412);
         check("t3_cnt", 32'(oper_cnt), 32'd2);
         check("t3_in_ready", 32'(in_ready), 32'd0);
         check("t3_valid", 32'(instr_valid), 32'd1);
         tick();
      end
      in_valid = 1'b0;
      check("t3_hold_opcode", 32'(opcode), 32'h83);
      consume();

      // 4: illegal count field; next byte waits for consume
      push(8'hC1);
      check("t4_valid", 32'(instr_valid), 32'd1);
      check("t4_illegal", 32'(illegal), 32'd1);
      check("t4_cnt", 32'(oper_cnt), 32'd0);
      in_valid = 1'b1;
      in_data  = 8'h42;
      tick();
      check("t4_blocked", 32'(opcode), 32'hC1);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check("t4_bubble", 32'(opcode), 32'hC1);
      tick();
      in_valid = 1'b0;
      check("t4_accept_op", 32'(opcode), 32'h42);
      check("t4_accept_cnt", 32'(oper_cnt), 32'd1);
      check("t4_accept_ill", 32'(illegal), 32'd0);
      push(8'h5A);
      check("t4_operand", 32'(operand), 32'h005A);
      consume();

      // 5: flush discards a concurrent input
      push(8'h41);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h99;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("t5_opcode", 32'(opcode), 32'h0);
      check("t5_cnt", 32'(oper_cnt), 32'd0);
      check("t5_operand", 32'(operand), 32'h0);
      check("t5_in_ready", 32'(in_ready), 32'd1);
      check("t5_valid", 32'(instr_valid), 32'd0);
      push(8'h41);
      push(8'h77);
      check("t5_operand2", 32'(operand), 32'h0077);
      check("t5_cnt2", 32'(oper_cnt), 32'd1);
      check("t5_opcode2", 32'(opcode), 32'h41);
      consume();

      // 6: back-to-back with instr_ready tied high
      instr_ready = 1'b1;
      in_valid    = 1'b1;
      in_data     = 8'h00;
      tick();
      check("t6_v1", 32'(instr_valid), 32'd1);
      check("t6_op1", 32'(opcode), 32'h00);
      check("t6_rdy1", 32'(in_ready), 32'd0);
      in_data = 8'h40;
      tick();
      check("t6_bubble_v", 32'(instr_valid), 32'd0);
      check("t6_bubble_op", 32'(opcode), 32'h00);
      tick();
      check("t6_op2", 32'(opcode), 32'h40);
      check("t6_cnt2", 32'(oper_cnt), 32'd1);
      in_data = 8'hAB;
      tick();
      in_valid = 1'b0;
      check("t6_v2", 32'(instr_valid), 32'd1);
      check("t6_operand2", 32'(operand), 32'h00AB);
      tick();
      check("t6_done", 32'(instr_valid), 32'd0);

      // flush wins over a simultaneous consume
      instr_ready = 1'b0;
      push(8'h05);
      instr_ready = 1'b1;
      flush       = 1'b1;
      tick();
      flush       = 1'b0;
      instr_ready = 1'b0;
      check("flush_consume_op", 32'(opcode), 32'h0);
      check("flush_consume_v", 32'(instr_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
